// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response bundle between the operand muxes, alu_seq
// and the status register.
//
// Handshake: a request transfers on a rising edge where in_valid && in_ready;
// a result transfers on a rising edge where out_valid && out_ready. A source
// holds valid and its payload steady until the transfer edge. A source never
// waits for ready before raising valid.
//
// Signals:
//   in_valid/in_ready     request handshake
//   op, operand1/2        operation code and A/B operands
//   carry_in              carry/borrow for ADC/SBC/ROL/ROR
//   out_valid/out_ready   result handshake
//   result, result_hi     result (low/high product half for MUL)
//   *_flag                Z/C/N/V status flags
//   busy                  multi-cycle operation in progress
interface alu_seq_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] operand1;
  logic [WIDTH-1:0] operand2;
  logic             carry_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             zero_flag;
  logic             carry_flag;
  logic             negative_flag;
  logic             overflow_flag;
  logic             busy;

  modport master (
    output in_valid, op, operand1, operand2, carry_in, out_ready,
    input  in_ready, out_valid, result, result_hi,
           zero_flag, carry_flag, negative_flag, overflow_flag, busy
  );

  modport slave (
    input  in_valid, op, operand1, operand2, carry_in, out_ready,
    output in_ready, out_valid, result, result_hi,
           zero_flag, carry_flag, negative_flag, overflow_flag, busy
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: registered WIDTH-bit ALU with Z/C/N/V flags and an iterative
// shift-add unsigned multiply.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   bus          alu_seq_if slave (request, result, flags, busy)
//   dbg_state_o  current FSM state (IDLE=0, MUL=1, DONE=2)
//
// Single-cycle ops compute straight from the request inputs and are
// registered on the accept edge. MUL captures its operands on the accept edge
// and then spends exactly WIDTH cycles in the MUL state, one shift-add step
// per cycle. Results are held in DONE until the consumer takes them.
module alu_seq #(
  parameter int WIDTH  = 8,
  parameter bit MUL_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  alu_seq_if.slave   bus,
  output logic [1:0] dbg_state_o
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic               z_q, z_d, c_q, c_d, n_q, n_d, v_q, v_d;
  // prod_q holds {partial high, unconsumed multiplier bits / low product}.
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic               in_ready;
  logic               accept;
  logic               is_mul;
  logic [WIDTH-1:0]   a, b;
  logic               ci;
  logic [WIDTH:0]     sum_w;
  logic [WIDTH-1:0]   alu_r;
  logic               alu_c, alu_v;
  logic [WIDTH:0]     step_sum;

  assign a  = bus.operand1;
  assign b  = bus.operand2;
  assign ci = bus.carry_in;

  assign in_ready = !rst && ((state_q == S_IDLE) ||
                             (state_q == S_DONE && bus.out_ready));
  assign accept   = bus.in_valid && in_ready;
  assign is_mul   = MUL_EN && (bus.op == 4'd12);

  // Single-cycle datapath; W+1-bit intermediates carry the carry/borrow.
  always_comb begin
    sum_w = '0;
    alu_r = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (bus.op)
      4'd0, 4'd8: begin
        sum_w = {1'b0, a} + {1'b0, b} +
                ((bus.op == 4'd8) ? {{WIDTH{1'b0}}, ci} : '0);
        alu_r = sum_w[WIDTH-1:0];
        alu_c = sum_w[WIDTH];
        // Same-sign operands producing a different-sign result.
        alu_v = (a[WIDTH-1] == b[WIDTH-1]) && (alu_r[WIDTH-1] != a[WIDTH-1]);
      end
      4'd1, 4'd9: begin
        sum_w = {1'b0, a} - {1'b0, b} -
                ((bus.op == 4'd9) ? {{WIDTH{1'b0}}, ci} : '0);
        alu_r = sum_w[WIDTH-1:0];
        alu_c = sum_w[WIDTH];  // borrow out
        alu_v = (a[WIDTH-1] != b[WIDTH-1]) && (alu_r[WIDTH-1] != a[WIDTH-1]);
      end
      4'd2:  alu_r = a & b;
      4'd3:  alu_r = a | b;
      4'd4:  alu_r = a ^ b;
      4'd5:  alu_r = ~a;
      4'd6: begin
        alu_r = {a[WIDTH-2:0], 1'b0};
        alu_c = a[WIDTH-1];
      end
      4'd7: begin
        alu_r = {1'b0, a[WIDTH-1:1]};
        alu_c = a[0];
      end
      4'd10: begin
        alu_r = {a[WIDTH-2:0], ci};
        alu_c = a[WIDTH-1];
      end
      4'd11: begin
        alu_r = {ci, a[WIDTH-1:1]};
        alu_c = a[0];
      end
      default: begin
        // Opcodes 13-15, and opcode 12 with MUL_EN=0: zero result, Z set.
        alu_r = '0;
      end
    endcase
  end

  // One shift-add step: add the multiplicand into the high half when the
  // current multiplier bit is set, then shift the whole product right.
  assign step_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
                    (prod_q[0] ? {1'b0, mcand_q} : '0);

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    hi_d    = hi_q;
    z_d     = z_q;
    c_d     = c_q;
    n_d     = n_q;
    v_d     = v_q;
    prod_d  = prod_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (state_q == S_DONE && bus.out_ready) state_d = S_IDLE;
        if (accept) begin
          if (is_mul) begin
            state_d = S_MUL;
            mcand_d = a;
            prod_d  = {{WIDTH{1'b0}}, b};
            cnt_d   = '0;
          end else begin
            state_d = S_DONE;
            res_d   = alu_r;
            hi_d    = '0;
            z_d     = (alu_r == '0);
            c_d     = alu_c;
            n_d     = alu_r[WIDTH-1];
            v_d     = alu_v;
          end
        end
      end
      S_MUL: begin
        prod_d = {step_sum, prod_q[WIDTH-1:1]};
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST_STEP) begin
          state_d = S_DONE;
          res_d   = prod_d[WIDTH-1:0];
          hi_d    = prod_d[2*WIDTH-1:WIDTH];
          z_d     = (prod_d == '0);
          c_d     = (prod_d[2*WIDTH-1:WIDTH] != '0);
          n_d     = 1'b0;
          v_d     = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      res_q   <= '0;
      hi_q    <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      n_q     <= 1'b0;
      v_q     <= 1'b0;
      prod_q  <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      hi_q    <= hi_d;
      z_q     <= z_d;
      c_q     <= c_d;
      n_q     <= n_d;
      v_q     <= v_d;
      prod_q  <= prod_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.out_valid     = (state_q == S_DONE);
  assign bus.busy          = (state_q == S_MUL);
  assign bus.result        = res_q;
  assign bus.result_hi     = hi_q;
  assign bus.zero_flag     = z_q;
  assign bus.carry_flag    = c_q;
  assign bus.negative_flag = n_q;
  assign bus.overflow_flag = v_q;
  assign dbg_state_o       = state_q;

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Registered, parametrised successor to the 8-bit combinational ALU in the 6502 core datapath.
- Generalises the datapath to WIDTH bits and adds carry-in operations, rotates, N/V flags and an iterative unsigned multiply.
- Sits between the register file/operand muxes and the status register.
- Uses a valid/ready handshake on both sides, so single-cycle and multi-cycle operations share one interface.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2).
- MUL_EN, 1, 1 = MUL opcode implemented; 0 = MUL treated as reserved.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept an operation.
- op  in  4  operation code.
- operand1  in  WIDTH  A operand.
- operand2  in  WIDTH  B operand.
- carry_in  in  1  carry/borrow input for ADC/SBC/ROL/ROR.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  result; low half of the product for MUL.
- result_hi  out  WIDTH  high half of the product for MUL; 0 for all other ops.
- zero_flag  out  1  Z.
- carry_flag  out  1  C.
- negative_flag  out  1  N.
- overflow_flag  out  1  V.
- busy  out  1  multi-cycle operation in progress.

Behaviour:
- States:
  - IDLE: in_ready=1.
  - MUL: busy=1, in_ready=0.
  - DONE: out_valid=1.
- Accept occurs when in_valid && in_ready. op, operands and carry_in are captured at accept; later input changes are ignored.
- Opcodes:
  - 0 ADD: {C,R}=A+B.
  - 1 SUB: {C,R}=A-B; C=1 means borrow.
  - 2 AND, 3 OR, 4 XOR: C=0.
  - 5 NOT: R=~A, C=0.
  - 6 SHL: R=A<<1, C=A[W-1].
  - 7 SHR: R=A>>1, C=A[0].
  - 8 ADC: A+B+carry_in.
  - 9 SBC: A-B-carry_in; C=borrow.
  - 10 ROL: R={A[W-2:0],carry_in}, C=A[W-1].
  - 11 ROR: R={carry_in,A[W-1:1]}, C=A[0].
  - 12 MUL: unsigned 2W-bit product.
  - 13-15 reserved: R=0, result_hi=0, Z=1, C=N=V=0.
- Flags:
  - Z=(R==0); for MUL, Z=({result_hi,R}==0).
  - N=R[W-1]; for MUL, N=0.
  - V = signed overflow for ADD/ADC/SUB/SBC, else 0.
  - MUL: C=(result_hi!=0), V=0.
- Latency:
  - Single-cycle ops: out_valid rises on the edge after accept (IDLE->DONE).
  - MUL: shift-add over exactly WIDTH cycles in state MUL; out_valid rises WIDTH+1 cycles after accept.
- DONE:
  - result, result_hi and flags are held stable until out_valid && out_ready.
  - No output bit changes while out_valid=1 && out_ready=0.
- in_ready = (state==IDLE) || (state==DONE && out_ready). This gives back-to-back throughput of one single-cycle op per clock.
- Simultaneous completion and new accept in DONE:
  - Single-cycle op: stay DONE with the new result.
  - MUL: go to MUL; out_valid=0 next cycle.
- DONE with out_ready and no new accept: go to IDLE; out_valid=0 next cycle.
- Reset values (rst=1 at an edge, any state including mid-MUL):
  - state=IDLE.
  - out_valid=0, busy=0.
  - result=0, result_hi=0, all flags=0.
  - Multiply accumulator cleared.
- in_ready=0 while rst=1 and 1 from the first cycle after rst deasserts.
- Any in-flight operation is discarded; no out_valid for it ever.
- Arithmetic uses W+1-bit intermediates. Wrap-around is modulo 2^W, with the carry-out going to C.

Test Plan:
- WIDTH=8, ADD 0xFF+0x01 -> out_valid 1 cycle after accept: R=0x00, Z=1, C=1, N=0, V=0. Then SUB 0x01-0x02 -> R=0xFF, C=1, N=1, V=0.
- ADC 0x7F+0x00, carry_in=1 -> R=0x80, N=1, V=1, C=0. SBC 0x80-0x00, carry_in=1 -> R=0x7F, V=1, C=0, N=0.
- MUL 0xFF*0xFF -> busy=1 and in_ready=0 for 8 cycles; out_valid exactly 9 cycles after accept: result_hi=0xFE, R=0x01, C=1, Z=0. MUL 0x00*0x37 -> Z=1, C=0.
- Backpressure: ROL 0x81, carry_in=0 -> R=0x02, C=1, held unchanged while out_ready=0 for 5 cycles. Then out_ready=1 with in_valid=1 every cycle streaming ROR 0x01, carry_in=1 -> R=0x80, C=1, N=1: one result per clock, none dropped or duplicated.
- Reset at MUL cycle 4 -> following edge: out_valid=0, busy=0, R=0, flags=0. After rst low: in_ready=1; ADD 0x10+0x20 -> R=0x30, no stale MUL result emitted.
- Reserved op 0xD with A=0x55, B=0xAA -> R=0x00, result_hi=0, Z=1, C=N=V=0. With MUL_EN=0, op 12 behaves identically to reserved, with latency 1.
